ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter.sv | 159 +++++++++++++++
 tb/tb_ahb_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// Two-master AHB-lite bus arbiter that holds the grant across fixed-length and INCR bursts.
// Optional macro AHB_ARB_ROUND_ROBIN_EN replaces fixed priority (master 0 wins ties) with round robin.
module ahb_arbiter (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic [1:0] hbusreq,
  output logic [1:0] hgrant,
  input  logic [1:0] m0_htrans,
  input  logic [1:0] m1_htrans,
  input  logic [2:0] m0_hburst,
  input  logic [2:0] m1_hburst,
  input  logic       hready,
  output logic       hmaster,
  output logic       hmaster_data
);

  localparam logic [1:0] ST_PARK  = 2'd0;
  localparam logic [1:0] ST_FIXED = 2'd1;
  localparam logic [1:0] ST_UNDEF = 2'd2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR = 3'b001;

  logic [1:0] state_q, state_d;
  logic [4:0] beat_q, beat_d;
  logic       hmaster_q, hmaster_d;
  logic       hmaster_data_q, hmaster_data_d;

  logic [1:0] ownHtrans;
  logic [2:0] ownHburst;
  logic [4:0] beatLoad;
  logic       burstFixed;
  logic       burstIncr;
  logic       arbPoint;
  logic       winner;

  always_comb begin
    ownHtrans = hmaster_q ? m1_htrans : m0_htrans;
    ownHburst = hmaster_q ? m1_hburst : m0_hburst;
  end

  // Beats remaining after the NONSEQ; the upper burst bits select 4/8/16 beats.
  always_comb begin
    case (ownHburst[2:1])
      2'b01:   beatLoad = 5'd3;
      2'b10:   beatLoad = 5'd7;
      2'b11:   beatLoad = 5'd15;
      default: beatLoad = 5'd0;
    endcase
    burstFixed = (ownHburst[2:1] != 2'b00);
    burstIncr  = (ownHburst == HBURST_INCR);
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    arbPoint = 1'b0;
    if (hready) begin
      case (state_q)
        ST_PARK: begin
          if (ownHtrans == HTRANS_NONSEQ) begin
            if (burstFixed) begin
              state_d = ST_FIXED;
              beat_d  = beatLoad;
            end else if (burstIncr) begin
              state_d = ST_UNDEF;
            end
          end else begin
            arbPoint = 1'b1;
          end
        end
        ST_FIXED: begin
          // The SEQ that takes the counter to zero is the final beat of the burst.
          if (ownHtrans == HTRANS_SEQ) begin
            if (beat_q <= 5'd1) begin
              state_d  = ST_PARK;
              beat_d   = 5'd0;
              arbPoint = 1'b1;
            end else begin
              beat_d = beat_q - 5'd1;
            end
          end
        end
        ST_UNDEF: begin
          if ((ownHtrans == HTRANS_IDLE) || (ownHtrans == HTRANS_NONSEQ)) begin
            state_d  = ST_PARK;
            arbPoint = 1'b1;
          end
        end
        default: begin
          state_d = ST_PARK;
          beat_d  = 5'd0;
        end
      endcase
    end
  end

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On a tie the master that did not win last time is chosen.
  always_comb begin
    last_d = last_q;
    case (hbusreq)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_q;
      default: winner = hmaster_q;
    endcase
    if (arbPoint && (hbusreq != 2'b00)) begin
      last_d = winner;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    case (hbusreq)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = 1'b0;
      default: winner = hmaster_q;
    endcase
  end
`endif

  always_comb begin
    hmaster_d      = arbPoint ? winner : hmaster_q;
    hmaster_data_d = hready ? hmaster_q : hmaster_data_q;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q        <= ST_PARK;
      beat_q         <= 5'd0;
      hmaster_q      <= 1'b0;
      hmaster_data_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
    end
  end

  assign hgrant       = {hmaster_q, ~hmaster_q};
  assign hmaster      = hmaster_q;
  assign hmaster_data = hmaster_data_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed burst scenarios then randomized traffic against a transaction-level model.
// Honours AHB_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_ahb_arbiter;

  logic       hclk;
  logic       hresetn;
  logic [1:0] hbusreq;
  logic [1:0] hgrant;
  logic [1:0] m0_htrans;
  logic [1:0] m1_htrans;
  logic [2:0] m0_hburst;
  logic [2:0] m1_hburst;
  logic       hready;
  logic       hmaster;
  logic       hmaster_data;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, what kind of burst is open and how many SEQs it still needs.
  int mOwner;
  int mData;
  int mMode;
  int mLeft;
  int mLast;

  ahb_arbiter dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .hbusreq      (hbusreq),
    .hgrant       (hgrant),
    .m0_htrans    (m0_htrans),
    .m1_htrans    (m1_htrans),
    .m0_hburst    (m0_hburst),
    .m1_hburst    (m1_hburst),
    .hready       (hready),
    .hmaster      (hmaster),
    .hmaster_data (hmaster_data)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  function automatic int burstBeats(input logic [2:0] b);
    if (b[2:1] == 2'b00) return 1;
    return 2 << b[2:1];
  endfunction

  task automatic modelReset();
    mOwner = 0;
    mData  = 0;
    mMode  = 0;
    mLeft  = 0;
    mLast  = 1;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    int t;
    int b;
    int req;
    int win;
    bit arb;
    if (!hready) return;
    t   = (mOwner == 1) ? int'(m1_htrans) : int'(m0_htrans);
    b   = (mOwner == 1) ? int'(m1_hburst) : int'(m0_hburst);
    req = int'(hbusreq);
    arb = 1'b0;
    if (mMode == 0) begin
      if (t == 2) begin
        if (b == 1) mMode = 2;
        else if (b >= 2) begin
          mMode = 1;
          mLeft = burstBeats(3'(b)) - 1;
        end
      end else arb = 1'b1;
    end else if (mMode == 1) begin
      if (t == 3) begin
        mLeft = mLeft - 1;
        if (mLeft == 0) begin
          mMode = 0;
          arb   = 1'b1;
        end
      end
    end else begin
      if (t == 0 || t == 2) begin
        mMode = 0;
        arb   = 1'b1;
      end
    end
    mData = mOwner;
    if (arb && req != 0) begin
      if (req == 1) win = 0;
      else if (req == 2) win = 1;
      else begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
        win = 1 - mLast;
`else
        win = 0;
`endif
      end
      mLast  = win;
      mOwner = win;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [1:0] expGrant;
    expGrant = (mOwner == 1) ? 2'b10 : 2'b01;
    checks++;
    assert (hgrant === expGrant) else begin
      errors++;
      $error("[TB] FAIL %s hgrant observed=%b expected=%b", tag, hgrant, expGrant);
    end
    checks++;
    assert (hmaster === 1'(mOwner)) else begin
      errors++;
      $error("[TB] FAIL %s hmaster observed=%b expected=%0d", tag, hmaster, mOwner);
    end
    checks++;
    assert (hmaster_data === 1'(mData)) else begin
      errors++;
      $error("[TB] FAIL %s hmaster_data observed=%b expected=%0d", tag, hmaster_data, mData);
    end
  endtask

  task automatic checkGrant(input string tag, input logic [1:0] expGrant);
    checks++;
    assert (hgrant === expGrant) else begin
      errors++;
      $error("[TB] FAIL %s hgrant observed=%b expected=%b", tag, hgrant, expGrant);
    end
  endtask

  // Drives one cycle of inputs, lets the edge happen, then compares against the model.
  task automatic applyStimulus(input string tag, input logic [1:0] req,
                               input logic [1:0] t0, input logic [2:0] b0,
                               input logic [1:0] t1, input logic [2:0] b1,
                               input logic rdy);
    hbusreq   = req;
    m0_htrans = t0;
    m0_hburst = b0;
    m1_htrans = t1;
    m1_hburst = b1;
    hready    = rdy;
    modelStep();
    @(posedge hclk);
    #1;
    checkOutput(tag);
  endtask

  // Asserts reset between edges and checks that the grant returns to master 0 without a clock.
  task automatic pulseReset(input string tag);
    #3;
    hresetn = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    checkGrant(tag, 2'b01);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
  endtask

  initial begin
    hresetn   = 1'b0;
    hbusreq   = 2'b00;
    m0_htrans = 2'b00;
    m1_htrans = 2'b00;
    m0_hburst = 3'b000;
    m1_hburst = 3'b000;
    hready    = 1'b1;
    modelReset();
    repeat (2) @(posedge hclk);
    #1;
    checkOutput("reset");
    checkGrant("reset_const", 2'b01);
    hresetn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus("idle_park", 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b1);
      checkGrant("idle_const", 2'b01);
    end

    // m0 INCR4 while m1 requests: grant must not move until the fourth beat is accepted.
    applyStimulus("lock_nonseq", 2'b10, 2'b10, 3'b011, 2'b00, 3'b000, 1'b1);
    checkGrant("lock_b1", 2'b01);
    applyStimulus("lock_seq2", 2'b10, 2'b11, 3'b011, 2'b00, 3'b000, 1'b1);
    checkGrant("lock_b2", 2'b01);
    applyStimulus("lock_seq3", 2'b10, 2'b11, 3'b011, 2'b00, 3'b000, 1'b1);
    checkGrant("lock_b3", 2'b01);
    applyStimulus("lock_seq4", 2'b10, 2'b11, 3'b011, 2'b00, 3'b000, 1'b1);
    checkGrant("lock_handover", 2'b10);

    // m1 INCR4 with two wait states on beat 3.
    applyStimulus("wait_nonseq", 2'b01, 2'b00, 3'b000, 2'b10, 3'b011, 1'b1);
    applyStimulus("wait_seq2", 2'b01, 2'b00, 3'b000, 2'b11, 3'b011, 1'b1);
    applyStimulus("wait_stall1", 2'b01, 2'b00, 3'b000, 2'b11, 3'b011, 1'b0);
    applyStimulus("wait_stall2", 2'b01, 2'b00, 3'b000, 2'b11, 3'b011, 1'b0);
    checkGrant("wait_held", 2'b10);
    applyStimulus("wait_seq3", 2'b01, 2'b00, 3'b000, 2'b11, 3'b011, 1'b1);
    checkGrant("wait_b3", 2'b10);
    applyStimulus("wait_seq4", 2'b01, 2'b00, 3'b000, 2'b11, 3'b011, 1'b1);
    checkGrant("wait_handover", 2'b01);

    // m1 INCR burst with a BUSY beat; m0 takes over only on the IDLE.
    applyStimulus("undef_grant1", 2'b10, 2'b00, 3'b000, 2'b00, 3'b000, 1'b1);
    applyStimulus("undef_nonseq", 2'b01, 2'b00, 3'b000, 2'b10, 3'b001, 1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus("undef_seq", 2'b01, 2'b00, 3'b000, (i == 3) ? 2'b01 : 2'b11, 3'b001, 1'b1);
      checkGrant("undef_hold", 2'b10);
    end
    applyStimulus("undef_idle", 2'b01, 2'b00, 3'b000, 2'b00, 3'b001, 1'b1);
    checkGrant("undef_switch", 2'b01);

    // Reset during beat 2 of an m1 INCR8.
    applyStimulus("rst_grant1", 2'b10, 2'b00, 3'b000, 2'b00, 3'b000, 1'b1);
    applyStimulus("rst_nonseq", 2'b10, 2'b00, 3'b000, 2'b10, 3'b101, 1'b1);
    applyStimulus("rst_seq2", 2'b10, 2'b00, 3'b000, 2'b11, 3'b101, 1'b1);
    pulseReset("rst_midburst");
    applyStimulus("rst_after", 2'b10, 2'b00, 3'b000, 2'b11, 3'b101, 1'b1);
    checkGrant("rst_park", 2'b10);

    // Tie-break sequence: SINGLE NONSEQs interleaved with IDLE arbitration cycles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus("tie_single", 2'b11, 2'b10, 3'b000, 2'b10, 3'b000, 1'b1);
      applyStimulus("tie_arb", 2'b11, 2'b00, 3'b000, 2'b00, 3'b000, 1'b1);
    end

    for (int i = 0; i < 3000; i++) begin
      logic [1:0] rq;
      logic [1:0] t0;
      logic [1:0] t1;
      logic [2:0] b0;
      logic [2:0] b1;
      logic       rdy;
      if ($urandom_range(0, 299) == 0) pulseReset("rand_reset");
      rq  = 2'($urandom);
      t0  = 2'($urandom);
      t1  = 2'($urandom);
      b0  = 3'($urandom);
      b1  = 3'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) t0 = 2'b11;
      if ($urandom_range(0, 2) != 0) t1 = 2'b11;
      applyStimulus("random", rq, t0, b0, t1, b1, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
